avalon_burst_master: RTL and testbench

AVALON_BURST_MASTER -- requirements
Module: avalon_burst_master

---
 rtl/avalon_burst_master.sv | 206 ++++++++++++++++++++
 tb/tb_avalon_burst_master.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_burst_master.sv
// Avalon-MM burst master: turns one client request into a single read or write burst.
// Latency: read command issued the cycle after acceptance; read data returned one cycle after readDataValid.
// Backpressure: waitRequest stalls commands/write beats; wrDataValid gaps stall writes; no read-side throttle.
//
// Ports:
//   clk, rst_n                      - clock, synchronous active-low reset
//   req*                            - request handshake (reqValid/reqReady), direction, start address, beat count
//   wrData*/wrByteEnable            - write beat stream (wrDataValid/wrDataReady)
//   rdDataValid/rdData/rdLast       - read beat stream, one cycle after the Avalon response
//   done                            - one-cycle pulse when a burst completes
//   address..burstCount, waitRequest, readData, readDataValid - Avalon-MM master side
module avalon_burst_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_MAX  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // request port
    input  logic                    reqValid,
    output logic                    reqReady,
    input  logic                    reqWrite,
    input  logic [ADDR_WIDTH-1:0]   reqAddress,
    input  logic [7:0]              reqLen,
    // write stream
    input  logic                    wrDataValid,
    output logic                    wrDataReady,
    input  logic [DATA_WIDTH-1:0]   wrData,
    input  logic [DATA_WIDTH/8-1:0] wrByteEnable,
    // read stream
    output logic                    rdDataValid,
    output logic [DATA_WIDTH-1:0]   rdData,
    output logic                    rdLast,
    output logic                    done,
    // Avalon master
    output logic [ADDR_WIDTH-1:0]   address,
    output logic [DATA_WIDTH/8-1:0] byteEnable,
    output logic                    read,
    output logic                    write,
    output logic [DATA_WIDTH-1:0]   writeData,
    output logic                    beginBurstTransfer,
    output logic [7:0]              burstCount,
    input  logic                    waitRequest,
    input  logic [DATA_WIDTH-1:0]   readData,
    input  logic                    readDataValid
);

    localparam int                    BE_WIDTH    = DATA_WIDTH / 8;
    localparam int                    ADDR_LSB    = $clog2(BE_WIDTH);
    localparam logic [7:0]            BURST_MAX_L = 8'(BURST_MAX);
    // Clears the sub-word byte offset so every burst starts word aligned.
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK   = {ADDR_WIDTH{1'b1}} << ADDR_LSB;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_CMD  = 2'd1,
        RD_DATA = 2'd2,
        WR_DATA = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   address_q, address_d;
    logic [7:0]              burst_count_q, burst_count_d;
    logic [7:0]              beat_cnt_q, beat_cnt_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    rd_data_vld_q, rd_data_vld_d;
    logic                    rd_last_q, rd_last_d;
    logic                    done_q, done_d;
    // Set on acceptance; drives beginBurstTransfer until the command (read)
    // or the first beat (write) has been presented/transferred.
    logic                    first_q, first_d;

    logic [7:0]              len_clamped;
    logic                    rd_beat;
    logic                    wr_beat;

    always_comb begin
        if (reqLen == 8'd0) begin
            len_clamped = 8'd1;
        end else if (reqLen > BURST_MAX_L) begin
            len_clamped = BURST_MAX_L;
        end else begin
            len_clamped = reqLen;
        end
    end

    always_comb begin
        state_d       = state_q;
        address_d     = address_q;
        burst_count_d = burst_count_q;
        beat_cnt_d    = beat_cnt_q;
        rd_data_d     = rd_data_q;
        rd_data_vld_d = 1'b0;
        rd_last_d     = 1'b0;
        done_d        = 1'b0;
        first_d       = first_q;
        rd_beat       = 1'b0;
        wr_beat       = 1'b0;

        reqReady           = 1'b0;
        read               = 1'b0;
        write              = 1'b0;
        beginBurstTransfer = 1'b0;
        byteEnable         = '0;
        writeData          = '0;
        wrDataReady        = 1'b0;

        case (state_q)
            IDLE: begin
                reqReady = 1'b1;
                if (reqValid) begin
                    address_d     = reqAddress & ADDR_MASK;
                    burst_count_d = len_clamped;
                    beat_cnt_d    = len_clamped;
                    first_d       = 1'b1;
                    state_d       = reqWrite ? WR_DATA : RD_CMD;
                end
            end
            RD_CMD: begin
                read               = 1'b1;
                byteEnable         = '1;
                beginBurstTransfer = first_q;
                first_d            = 1'b0;
                if (!waitRequest) begin
                    state_d = RD_DATA;
                    // A response may already arrive in the command-accept cycle.
                    rd_beat = readDataValid;
                end
            end
            RD_DATA: begin
                rd_beat = readDataValid;
            end
            WR_DATA: begin
                write              = wrDataValid;
                writeData          = wrData;
                byteEnable         = wrByteEnable;
                wrDataReady        = !waitRequest;
                beginBurstTransfer = first_q;
                wr_beat            = wrDataValid && !waitRequest;
                if (wr_beat) begin
                    first_d    = 1'b0;
                    beat_cnt_d = beat_cnt_q - 8'd1;
                    if (beat_cnt_q == 8'd1) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rd_beat) begin
            rd_data_d     = readData;
            rd_data_vld_d = 1'b1;
            beat_cnt_d    = beat_cnt_q - 8'd1;
            if (beat_cnt_q == 8'd1) begin
                rd_last_d = 1'b1;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
        end

        // Handshake and command strobes stay quiet for the whole reset cycle.
        if (!rst_n) begin
            reqReady           = 1'b0;
            read               = 1'b0;
            write              = 1'b0;
            beginBurstTransfer = 1'b0;
            wrDataReady        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            address_q     <= '0;
            burst_count_q <= '0;
            beat_cnt_q    <= '0;
            rd_data_q     <= '0;
            rd_data_vld_q <= 1'b0;
            rd_last_q     <= 1'b0;
            done_q        <= 1'b0;
            first_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            address_q     <= address_d;
            burst_count_q <= burst_count_d;
            beat_cnt_q    <= beat_cnt_d;
            rd_data_q     <= rd_data_d;
            rd_data_vld_q <= rd_data_vld_d;
            rd_last_q     <= rd_last_d;
            done_q        <= done_d;
            first_q       <= first_d;
        end
    end

    assign address     = address_q;
    assign burstCount  = burst_count_q;
    assign rdData      = rd_data_q;
    assign rdDataValid = rd_data_vld_q;
    assign rdLast      = rd_last_q;
    assign done        = done_q;

endmodule

// File: tb/tb_avalon_burst_master.sv
// Scoreboard bench for avalon_burst_master (DATA_WIDTH 32, BURST_MAX 8).
// Inputs change 1 ns after the rising edge; all sampling happens on the falling edge.
// Read beats and write beats are queued as driven and popped when the DUT presents them.
module tb_avalon_burst_master;

    localparam int MODE_NONE = 0;
    localparam int MODE_RD   = 1;
    localparam int MODE_WR   = 2;

    logic        clk;
    logic        rst_n;
    logic        reqValid, reqReady, reqWrite;
    logic [31:0] reqAddress;
    logic [7:0]  reqLen;
    logic        wrDataValid, wrDataReady;
    logic [31:0] wrData;
    logic [3:0]  wrByteEnable;
    logic        rdDataValid, rdLast, done;
    logic [31:0] rdData;
    logic [31:0] address;
    logic [3:0]  byteEnable;
    logic        read, write, beginBurstTransfer;
    logic [31:0] writeData;
    logic [7:0]  burstCount;
    logic        waitRequest, readDataValid;
    logic [31:0] readData;

    int checks = 0;
    int errors = 0;
    int mode = MODE_NONE;
    bit mon_en = 0;
    bit exp_beat = 0;
    bit exp_pipe = 0;
    int exp_addr, exp_bc;
    int read_cycles, begin_cnt, rd_pulses, done_cnt, wr_xfers;
    logic [32:0] rd_q[$];
    logic [35:0] wr_q[$];

    avalon_burst_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_MAX(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqAddress(reqAddress), .reqLen(reqLen),
        .wrDataValid(wrDataValid), .wrDataReady(wrDataReady),
        .wrData(wrData), .wrByteEnable(wrByteEnable),
        .rdDataValid(rdDataValid), .rdData(rdData), .rdLast(rdLast), .done(done),
        .address(address), .byteEnable(byteEnable), .read(read), .write(write),
        .writeData(writeData), .beginBurstTransfer(beginBurstTransfer),
        .burstCount(burstCount), .waitRequest(waitRequest),
        .readData(readData), .readDataValid(readDataValid)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int clamp_len(input int len);
        if (len == 0) return 1;
        if (len > 8) return 8;
        return len;
    endfunction

    // Advance to just after the next rising edge; single-cycle strobes drop.
    task automatic step();
        @(posedge clk);
        #1;
        reqValid      = 0;
        readDataValid = 0;
        exp_beat      = 0;
    endtask

    task automatic push_rd_beat(input logic last);
        logic [31:0] d;
        d = $urandom;
        readDataValid = 1;
        readData      = d;
        exp_beat      = 1;
        rd_q.push_back({last, d});
    endtask

    // Falling-edge monitor: read-return scoreboard, Avalon command checks.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [32:0] re;
            logic [35:0] we;
            check("rdv_latency", rdDataValid, exp_pipe);
            exp_pipe = exp_beat;
            if (rdDataValid) begin
                rd_pulses++;
                if (rd_q.size() == 0) begin
                    check("rd_extra_beat", 1, 0);
                end else begin
                    re = rd_q.pop_front();
                    check("rd_data", rdData, re[31:0]);
                    check("rd_last", rdLast, re[32]);
                end
            end
            if (done) begin
                done_cnt++;
                if (mode == MODE_RD) check("done_with_last", rdLast, 1);
            end
            if (read) begin
                check("rd_cmd_addr", address, exp_addr);
                check("rd_cmd_bc", burstCount, exp_bc);
                check("rd_cmd_be", byteEnable, 4'hF);
                if (beginBurstTransfer) check("rd_begin_first", read_cycles, 0);
                read_cycles++;
                if (beginBurstTransfer) begin_cnt++;
            end
            if (mode == MODE_WR) begin
                check("wr_write", write, wrDataValid && rst_n);
                check("wr_ready", wrDataReady, !waitRequest && rst_n);
                check("wr_begin", beginBurstTransfer, rst_n && (wr_xfers == 0));
                check("wr_addr", address, exp_addr);
                check("wr_bc", burstCount, exp_bc);
                if (write && !waitRequest) begin
                    wr_xfers++;
                    if (wr_q.size() == 0) begin
                        check("wr_extra_beat", 1, 0);
                    end else begin
                        we = wr_q.pop_front();
                        check("wr_data", writeData, we[31:0]);
                        check("wr_be", byteEnable, we[35:32]);
                    end
                end
            end else begin
                check("no_wr_ready", wrDataReady, 0);
                if (mode == MODE_NONE) check("idle_strobes", {read, write, beginBurstTransfer}, 3'b000);
            end
        end
    end

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                           input int wait_n, input bit overlap);
        int bc, left;
        bc = clamp_len(int'(len));
        exp_addr = addr & 32'hFFFF_FFFC;
        exp_bc = bc;
        read_cycles = 0; begin_cnt = 0; rd_pulses = 0; done_cnt = 0;
        mode = MODE_RD;
        step();
        reqValid = 1; reqWrite = 0; reqAddress = addr; reqLen = len;
        @(negedge clk);
        check("rd_req_ready", reqReady, 1);
        step();
        waitRequest = (wait_n > 0);
        for (int i = 1; i < wait_n; i++) step();
        if (wait_n > 0) begin
            step();
            waitRequest = 0;
        end
        left = bc;
        if (overlap) begin
            push_rd_beat(left == 1);
            left--;
        end
        for (int k = 0; left > 0; k++) begin
            step();
            if (k == 1) step();
            push_rd_beat(left == 1);
            left--;
        end
        for (int i = 0; i < 20 && done_cnt == 0; i++) step();
        step();
        step();
        check("rd_done_cnt", done_cnt, 1);
        check("rd_pulses", rd_pulses, bc);
        check("rd_cmd_cycles", read_cycles, wait_n + 1);
        check("rd_begin_cnt", begin_cnt, 1);
        check("rd_q_empty", rd_q.size(), 0);
        mode = MODE_NONE;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input bit stall_first,
                            input int gap_beat, input int gap_len, input int abort_after);
        int bc, sent, gap_left;
        logic [31:0] d;
        logic [3:0]  be;
        bc = clamp_len(int'(len));
        exp_addr = addr & 32'hFFFF_FFFC;
        exp_bc = bc;
        wr_xfers = 0; done_cnt = 0; sent = 0; gap_left = gap_len;
        step();
        reqValid = 1; reqWrite = 1; reqAddress = addr; reqLen = len;
        @(negedge clk);
        check("wr_req_ready", reqReady, 1);
        d = $urandom;
        be = 4'($urandom);
        for (int cyc = 0; sent < bc && cyc < 200; cyc++) begin
            step();
            mode = MODE_WR;
            if (abort_after != 0 && sent == abort_after) begin
                rst_n = 0; wrDataValid = 1; wrData = d; wrByteEnable = be; waitRequest = 0;
                @(negedge clk);
                check("abort_write_in_rst", write, 0);
                check("abort_ready_in_rst", reqReady, 0);
                step();
                rst_n = 1; wrDataValid = 0; mode = MODE_NONE;
                @(negedge clk);
                check("abort_write_after", write, 0);
                check("abort_idle_ready", reqReady, 1);
                check("abort_no_done", done, 0);
                check("abort_bc_clr", burstCount, 0);
                check("abort_addr_clr", address, 0);
                return;
            end
            waitRequest = stall_first && (cyc == 0);
            if (gap_left > 0 && sent == gap_beat - 1) begin
                wrDataValid = 0;
                gap_left--;
            end else begin
                wrDataValid = 1; wrData = d; wrByteEnable = be;
                if (!waitRequest) begin
                    wr_q.push_back({be, d});
                    sent++;
                    d = $urandom;
                    be = 4'($urandom);
                end
            end
        end
        step();
        mode = MODE_NONE; wrDataValid = 0; waitRequest = 0;
        @(negedge clk);
        check("wr_done_pulse", done, 1);
        check("wr_idle_ready", reqReady, 1);
        step();
        @(negedge clk);
        check("wr_done_cnt", done_cnt, 1);
        check("wr_xfers", wr_xfers, bc);
        check("wr_q_empty", wr_q.size(), 0);
    endtask

    initial begin
        rst_n = 0; reqValid = 1; reqWrite = 0; reqAddress = 32'h1234; reqLen = 8'd4;
        wrDataValid = 0; wrData = 0; wrByteEnable = 0;
        waitRequest = 1; readData = 0; readDataValid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", reqReady, 0);
        check("rst_strobes", {read, write, beginBurstTransfer, wrDataReady}, 4'b0000);
        check("rst_rd_outs", {rdDataValid, rdLast, done}, 3'b000);
        check("rst_addr", address, 0);
        check("rst_bc", burstCount, 0);
        check("rst_rddata", rdData, 0);
        step();
        rst_n = 1; waitRequest = 0; mon_en = 1;
        @(negedge clk);
        check("post_rst_ready", reqReady, 1);

        do_read(32'h0000_1003, 8'd4, 2, 0);
        do_read(32'h0000_2007, 8'd0, 0, 1);
        do_read(32'h0000_3000, 8'd5, 1, 1);
        do_write(32'h0000_4002, 8'd3, 1, 2, 2, 0);
        do_write(32'h0000_5000, 8'd20, 0, 0, 0, 0);

        // Stray responses while idle must be dropped.
        rd_pulses = 0;
        step();
        readDataValid = 1; readData = 32'hDEAD_BEEF;
        @(negedge clk);
        check("stray_ready_1", reqReady, 1);
        step();
        readDataValid = 1; readData = 32'hCAFE_F00D;
        @(negedge clk);
        check("stray_ready_2", reqReady, 1);
        step();
        step();
        check("stray_no_rdv", rd_pulses, 0);

        do_write(32'h0000_6000, 8'd8, 0, 0, 0, 2);
        step();
        step();
        check("abort_done_cnt", done_cnt, 0);
        do_read(32'h0000_7004, 8'd2, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
